// File: rtl/nibble_serial_adder_if.sv
// Valid/ready operand and result channels of the nibble-serial adder.
// The master modport belongs to the source/consumer side, the slave modport to the adder.
interface nibble_serial_adder_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_s;
    logic         out_co;
    logic         out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_ci, out_ready,
        input  in_ready, out_valid, out_s, out_co, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_ci, out_ready,
        output in_ready, out_valid, out_s, out_co, out_ovf
    );
endinterface

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit add slice, processing one nibble per cycle, LSB first.
// A registered carry links successive nibbles; both sides use valid/ready handshakes.
module nibble_serial_adder #(
    parameter int NIB = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_serial_adder_if.slave  bus
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  s_q;
    logic          co_q;
    logic          ovf_q;
    logic          carry_q;
    logic [CW-1:0] cnt_q;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [4:0]    slice_d;
    logic          c3_d;

    // The single shared 4-bit slice; c3_d recovers the carry into its top bit.
    always_comb begin
        nib_a   = a_q[4*cnt_q +: 4];
        nib_b   = b_q[4*cnt_q +: 4];
        slice_d = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0000, carry_q};
        c3_d    = slice_d[3] ^ nib_a[3] ^ nib_b[3];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        carry_q    <= bus.in_ci;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    s_q[4*cnt_q +: 4] <= slice_d[3:0];
                    carry_q           <= slice_d[4];
                    if (cnt_q == LAST) begin
                        co_q        <= slice_d[4];
                        ovf_q       <= c3_d ^ slice_d[4];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_s     = s_q;
    assign bus.out_co    = co_q;
    assign bus.out_ovf   = ovf_q;
endmodule
